// File: rtl/header_assembler_pkg.sv
// Shared miner package: header geometry and the assembler state encoding.
// Also imported by the miner control block, so header size constants live
// here rather than being re-derived in each consumer.
package header_assembler_pkg;

  localparam int HDR_BYTES = 80;              // bytes per block header
  localparam int HDR_W     = HDR_BYTES * 8;   // header width in bits

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECV   = 2'd1,
    ST_COMMIT = 2'd2
  } hdr_state_e;

endpackage

// File: rtl/header_assembler_byte_shift_reg.sv
// byte_shift_reg: MSB-first byte shifter for header assembly.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   clear        : zero the register before this cycle's shift
//   shift_en     : shift din into the low byte, older bytes move up
//   din          : byte to shift in
//   data_next    : register value after this cycle's clear/shift, so the
//                  caller can capture a header in the same edge its final
//                  byte lands (BYTES must be >= 2)
module byte_shift_reg #(
  parameter int BYTES = 80
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 shift_en,
  input  logic [7:0]           din,
  output logic [BYTES*8-1:0]   data_next
);

  localparam int W = BYTES * 8;

  logic [W-1:0] data_q, data_d, base;

  always_comb begin
    base   = clear ? '0 : data_q;
    data_d = base;
    if (shift_en) data_d = {base[W-9:0], din};
  end

  always_ff @(posedge clock) begin
    if (reset) data_q <= '0;
    else       data_q <= data_d;
  end

  assign data_next = data_d;

endmodule

// File: rtl/header_assembler.sv
// header_assembler: collects UART bytes into a fixed-size block header.
// A header is published on block_header (first byte in the top byte) for
// exactly one COMMIT cycle, flagged by header_ready. Partial headers are
// discarded on an idle timeout or a receiver error (abort pulse).
// Ports:
//   clock, reset   : single clock, synchronous active-high reset
//   rx_valid/byte  : received byte strobe and data
//   rx_error       : framing/parity error strobe
//   block_header   : last complete header
//   header_ready   : one-cycle pulse, new block_header valid
//   byte_count     : accepted bytes since reset (wraps mod 2^32)
//   busy           : partial header held
//   abort          : one-cycle pulse, partial header discarded
module header_assembler
  import header_assembler_pkg::*;
#(
  parameter int HEADER_BYTES   = HDR_BYTES,
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_byte,
  input  logic                      rx_error,
  output logic [HEADER_BYTES*8-1:0] block_header,
  output logic                      header_ready,
  output logic [31:0]               byte_count,
  output logic                      busy,
  output logic                      abort
);

  localparam int HW = HEADER_BYTES * 8;
  localparam int FW = $clog2(HEADER_BYTES + 1);
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILL_LAST = FW'(HEADER_BYTES);
  // Expiry is detected on the cycle the counter would reach TIMEOUT_CYCLES.
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);

  hdr_state_e    state_q, state_d;
  logic [FW-1:0] fill_q, fill_d, fill_inc;
  logic [IW-1:0] idle_q, idle_d;
  logic [31:0]   byte_count_q, byte_count_d;
  logic [HW-1:0] block_header_q, block_header_d;
  logic          abort_q, abort_d;

  logic          in_recv, drop, accept, last_byte, shift_clear;
  logic [HW-1:0] shift_next;

  // An error only matters while a partial header is held; it then also
  // swallows any byte strobed in the same cycle.
  assign in_recv   = (state_q == ST_RECV);
  assign drop      = in_recv & rx_error;
  assign accept    = rx_valid & ~drop;
  assign fill_inc  = (in_recv ? fill_q : '0) + FW'(1);
  assign last_byte = (fill_inc == FILL_LAST);

  byte_shift_reg #(.BYTES(HEADER_BYTES)) u_shift (
    .clock     (clock),
    .reset     (reset),
    .clear     (shift_clear),
    .shift_en  (accept),
    .din       (rx_byte),
    .data_next (shift_next)
  );

  always_comb begin
    state_d        = state_q;
    fill_d         = fill_q;
    idle_d         = idle_q;
    block_header_d = block_header_q;
    byte_count_d   = byte_count_q + {31'd0, accept};
    abort_d        = 1'b0;
    shift_clear    = 1'b0;

    unique case (state_q)
      ST_RECV: begin
        if (drop) begin
          state_d = ST_IDLE;
          fill_d  = '0;
          idle_d  = '0;
          abort_d = 1'b1;
        end else if (accept) begin
          // A byte on the expiry cycle cancels the timeout.
          fill_d = fill_inc;
          idle_d = '0;
          if (last_byte) state_d = ST_COMMIT;
        end else if (idle_q == IDLE_LAST) begin
          state_d = ST_IDLE;
          fill_d  = '0;
          idle_d  = '0;
          abort_d = 1'b1;
        end else begin
          idle_d = idle_q + IW'(1);
        end
      end
      default: begin
        // IDLE and COMMIT both fall back to IDLE unless a byte starts the
        // next header; COMMIT therefore never loses a byte.
        state_d = ST_IDLE;
        fill_d  = '0;
        idle_d  = '0;
        if (accept) begin
          shift_clear = 1'b1;
          fill_d      = fill_inc;
          state_d     = last_byte ? ST_COMMIT : ST_RECV;
        end
      end
    endcase

    // Capture on the edge into COMMIT so the header is valid with header_ready.
    if (accept && last_byte) block_header_d = shift_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      fill_q         <= '0;
      idle_q         <= '0;
      byte_count_q   <= '0;
      block_header_q <= '0;
      abort_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      fill_q         <= fill_d;
      idle_q         <= idle_d;
      byte_count_q   <= byte_count_d;
      block_header_q <= block_header_d;
      abort_q        <= abort_d;
    end
  end

  assign block_header = block_header_q;
  assign header_ready = (state_q == ST_COMMIT);
  assign byte_count   = byte_count_q;
  assign busy         = (state_q == ST_RECV);
  assign abort        = abort_q;

endmodule

// File: tb/tb_header_assembler.sv
module tb_header_assembler;

  localparam int HB = 80;
  localparam int T  = 100;
  localparam int HW = HB * 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          rx_error = 1'b0;
  logic [HW-1:0] block_header;
  logic          header_ready;
  logic [31:0]   byte_count;
  logic          busy;
  logic          abort;

  always #5 clock = ~clock;

  header_assembler #(.HEADER_BYTES(HB), .TIMEOUT_CYCLES(T)) dut (
    .clock        (clock),
    .reset        (reset),
    .rx_valid     (rx_valid),
    .rx_byte      (rx_byte),
    .rx_error     (rx_error),
    .block_header (block_header),
    .header_ready (header_ready),
    .byte_count   (byte_count),
    .busy         (busy),
    .abort        (abort)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int tick  = 0;

  typedef struct packed { logic [HW-1:0] hdr; logic [31:0] cnt; int due; } hdr_exp_t;
  typedef struct packed { logic [31:0] cnt; int due; } abt_exp_t;

  hdr_exp_t hdr_q[$];
  abt_exp_t abt_q[$];

  // reference model state
  logic [7:0]    part[$];
  int            idle_n = 0;
  logic [31:0]   m_cnt = '0;
  logic [HW-1:0] m_last = '0;
  int            m_hdrs = 0;
  int            m_abts = 0;

  int hdr_seen = 0;
  int abt_seen = 0;

  initial forever begin
    @(posedge clock);
    tick++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_hdr(input string nm, input logic [HW-1:0] act, input logic [HW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One cycle of behaviour: a header is an ordered list of HB bytes; an
  // error while bytes are pending discards them (and any byte alongside);
  // T silent cycles after the last byte also discard them.
  task automatic model_step(input logic v, input logic [7:0] b, input logic e);
    logic [HW-1:0] h;
    if (part.size() != 0 && e) begin
      part.delete();
      idle_n = 0;
      m_abts++;
      abt_q.push_back('{cnt: m_cnt, due: tick + 1});
      return;
    end
    if (v) begin
      m_cnt = m_cnt + 32'd1;
      part.push_back(b);
      idle_n = 0;
      if (part.size() == HB) begin
        h = '0;
        foreach (part[i]) h = {h[HW-9:0], part[i]};
        m_last = h;
        m_hdrs++;
        hdr_q.push_back('{hdr: h, cnt: m_cnt, due: tick + 1});
        part.delete();
      end
    end else if (part.size() != 0) begin
      idle_n++;
      if (idle_n == T) begin
        part.delete();
        idle_n = 0;
        m_abts++;
        abt_q.push_back('{cnt: m_cnt, due: tick + 1});
      end
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] b, input logic e);
    @(negedge clock);
    rx_valid = v;
    rx_byte  = b;
    rx_error = e;
    model_step(v, b, e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0);
  endtask

  task automatic send_seq(input int n, input int start, input int gap);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 8'(start + i), 1'b0);
      idle(gap);
    end
  endtask

  task automatic send_rand(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 8'($urandom), 1'b0);
      idle(gap);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_error = 1'b0;
    part.delete();
    idle_n = 0;
    m_cnt  = '0;
    m_last = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ready"}, header_ready, 1'b0);
    chk({nm, "_abort"}, abort, 1'b0);
    chk({nm, "_busy"}, busy, 1'b0);
    chk({nm, "_count"}, byte_count, 32'd0);
    chk_hdr({nm, "_header"}, block_header, '0);
  endtask

  // monitor: pops expectations when the DUT pulses, and holds block_header
  // to the last committed value on every other cycle
  initial begin
    hdr_exp_t      he;
    abt_exp_t      ae;
    logic [HW-1:0] mon_last;
    mon_last = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        mon_last = '0;
      end else begin
        if (header_ready) begin
          hdr_seen++;
          chk("hdr_expected", hdr_q.size() != 0, 1'b1);
          if (hdr_q.size() != 0) begin
            he = hdr_q.pop_front();
            chk_hdr("hdr_value", block_header, he.hdr);
            chk("hdr_count", byte_count, he.cnt);
            chk("hdr_time", tick, he.due);
            mon_last = he.hdr;
          end
        end else begin
          chk_hdr("hdr_stable", block_header, mon_last);
        end
        if (abort) begin
          abt_seen++;
          chk("abort_expected", abt_q.size() != 0, 1'b1);
          if (abt_q.size() != 0) begin
            ae = abt_q.pop_front();
            chk("abort_count", byte_count, ae.cnt);
            chk("abort_time", tick, ae.due);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk_zero("reset");

    // 80 bytes 0x00..0x4F, one every 10 cycles
    send_seq(HB, 0, 9);
    chk("seq_pulses", hdr_seen, 1);
    chk("seq_first", block_header[HW-1:HW-8], 8'h00);
    chk("seq_last", block_header[7:0], 8'h4F);
    chk("seq_count", byte_count, 32'd80);

    // 40 bytes then silence -> timeout abort
    send_rand(40, 2);
    chk("part_busy", busy, 1'b1);
    idle(T + 5);
    chk("to_aborts", abt_seen, 1);
    chk("to_busy", busy, 1'b0);
    chk_hdr("to_header_kept", block_header, m_last);
    chk("to_count", byte_count, 32'd120);

    // byte landing on the expiry cycle keeps the header alive
    send_rand(5, 0);
    idle(T - 1);
    cyc(1'b1, 8'h5A, 1'b0);
    idle(T - 1);
    cyc(1'b1, 8'hA5, 1'b0);
    idle(3);
    chk("edge_no_abort", abt_seen, 1);
    chk("edge_busy", busy, 1'b1);
    idle(T + 2);
    chk("edge_abort", abt_seen, 2);

    // error together with a byte after 30 bytes
    send_seq(30, 8'h80, 1);
    cyc(1'b1, 8'hEE, 1'b1);
    idle(3);
    chk("err_aborts", abt_seen, 3);
    chk("err_count", byte_count, m_cnt);
    chk("err_busy", busy, 1'b0);
    send_rand(HB, 0);
    idle(3);
    chk("err_recover", hdr_seen, 2);

    // back-to-back headers, byte 81 lands in COMMIT
    send_seq(2 * HB, 8'h10, 0);
    idle(3);
    chk("b2b_pulses", hdr_seen, 4);
    chk("b2b_first", block_header[HW-1:HW-8], 8'h60);
    chk("b2b_last", block_header[7:0], 8'hAF);
    chk("b2b_count", byte_count, m_cnt);

    // reset mid-header
    send_rand(50, 1);
    do_reset();
    chk_zero("midrst");
    chk("midrst_no_abort", abt_seen, 3);
    send_seq(HB, 8'h20, 1);
    idle(3);
    chk("midrst_hdr", hdr_seen, 5);
    chk("midrst_count", byte_count, 32'd80);

    // random traffic, errors and long gaps around the timeout
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom % 3) != 0, 8'($urandom), ($urandom % 50) == 0);
      if (($urandom % 40) == 0) idle($urandom_range(T - 8, T + 8));
    end
    idle(T + 5);
    chk("rand_count", byte_count, m_cnt);
    chk("rand_busy", busy, 1'b0);

    // byte_count wrap
    idle(1);
    force dut.byte_count_q = 32'hFFFF_FFFE;
    idle(1);
    release dut.byte_count_q;
    m_cnt = 32'hFFFF_FFFE;
    send_seq(3, 1, 0);
    idle(2);
    chk("wrap_count", byte_count, 32'h0000_0001);
    idle(T + 5);

    chk("hdr_total", hdr_seen, m_hdrs);
    chk("abort_total", abt_seen, m_abts);
    chk("hdr_drained", hdr_q.size(), 0);
    chk("abort_drained", abt_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/header_assembler.md
HEADER_ASSEMBLER -- requirements
Module: header_assembler

Interface
REQ-001 Parameter HEADER_BYTES, default 80, sets the number of bytes per block header.
REQ-002 Parameter TIMEOUT_CYCLES, default 5_000_000 (100 ms at 50 MHz), sets the maximum idle gap between bytes of one header.
REQ-003 clock  in  1  uartClock domain, single clock; all logic SHALL be on the rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 rx_valid  in  1  one-cycle strobe: rx_byte holds a received byte.
REQ-006 rx_byte  in  8  received UART byte.
REQ-007 rx_error  in  1  one-cycle framing/parity error strobe from the UART receiver.
REQ-008 block_header  out  640  last complete header; first received byte at [639:632], last at [7:0] (nonce field = [31:0]).
REQ-009 header_ready  out  1  one-cycle pulse: a new block_header is valid (drives processor/miner restart).
REQ-010 byte_count  out  32  total accepted bytes since reset, for the display.
REQ-011 busy  out  1  high while a partial header is held.
REQ-012 abort  out  1  one-cycle pulse: partial header discarded (timeout or error).

Function
REQ-013 States SHALL be IDLE, RECV and COMMIT.
- IDLE: rx_valid -> RECV, with the byte stored and fill count 1.
- RECV: each rx_valid SHALL shift the byte in (MSB first) and increment the fill count.
- RECV: the byte making the fill count HEADER_BYTES -> COMMIT.
- COMMIT: lasts exactly one cycle, then -> IDLE.
REQ-014 block_header SHALL change only in COMMIT, loaded from the internal shift register; partial data SHALL never appear on it.
REQ-015 header_ready SHALL be asserted for exactly the COMMIT cycle, i.e. one cycle after the final byte's rx_valid.
REQ-016 block_header SHALL equal the new value in the same cycle header_ready is high.
REQ-017 A rx_valid arriving during COMMIT SHALL be accepted as byte 1 of the next header (state -> RECV); no byte is lost.
REQ-018 byte_count SHALL increment by 1 on every accepted rx_valid, including bytes later discarded.
REQ-019 byte_count SHALL wrap modulo 2^32.
REQ-020 The idle counter SHALL clear on every accepted byte and count cycles while in RECV.
REQ-021 When the idle counter reaches TIMEOUT_CYCLES in RECV: discard the partial header, pulse abort, go to IDLE.
REQ-022 rx_error in RECV: discard the partial header, pulse abort, go to IDLE.
REQ-023 rx_error in IDLE or COMMIT SHALL be ignored (no abort).
REQ-024 rx_error and rx_valid in the same cycle: the error wins, the byte is dropped and not counted.
REQ-025 Timeout expiry and rx_valid in the same cycle: the byte wins and the timeout is cancelled.
REQ-026 busy SHALL be 1 in RECV and 0 in IDLE and COMMIT.
REQ-027 The fill counter SHALL be 7 bits, sized by $clog2(HEADER_BYTES+1); the idle counter SHALL be sized by $clog2(TIMEOUT_CYCLES+1).

Reset
REQ-028 On reset: state IDLE, block_header 0, byte_count 0, header_ready 0, abort 0, busy 0, counters 0, shift register 0.
REQ-029 Reset mid-header SHALL discard the partial header without an abort pulse.

Structure
REQ-030 The state enumeration and the HEADER_BYTES / header width constants SHALL live in a shared miner package also used by minerControl.
REQ-031 One sub-module is natural: byte_shift_reg, the 640-bit MSB-first byte shifter with a load-clear input.
REQ-032 The FSM and counters SHALL stay in header_assembler.

Verification
REQ-033 Send 80 bytes 0x00..0x4F, one every 10 cycles -> one header_ready pulse 1 cycle after byte 80; block_header[639:632]=0x00, [7:0]=0x4F; byte_count=80.
REQ-034 Send 40 bytes, then idle with TIMEOUT_CYCLES=100 -> abort pulses after 100 idle cycles; busy=0; block_header unchanged; byte_count=40.
REQ-035 Send 30 bytes, then rx_error together with rx_valid -> abort; byte_count=30; a following 80-byte burst yields a correct header.
REQ-036 Two back-to-back 80-byte headers with byte 1 of the second arriving in the COMMIT cycle -> two header_ready pulses; the second header starts with that byte; byte_count=160.
REQ-037 Assert reset after byte 50 -> all outputs 0, no abort; the next 80 bytes form a valid header.
REQ-038 byte_count preset near 0xFFFFFFFE via force, then send 3 bytes -> byte_count wraps to 0x00000001.
